kernel_row_reader: RTL



---
 rtl/kernel_pkg.sv | 26 ++
 rtl/kernel_row_reader_if.sv | 33 +++
 rtl/kernel_addr_counter.sv | 76 +++++++
 rtl/kernel_row_reader.sv | 128 ++++++++++++
 4 files changed

// File: rtl/kernel_pkg.sv
// kernel_pkg: shared definitions for the kernel row reader.
//   KERNEL_SIZE : width of the horizontal row segment (pixels per triple).
//   state_t     : reader FSM states, 3-bit encoding.
//   clogb2      : number of bits needed to hold values 0..value-1 (minimum 1).
package kernel_pkg;

  localparam int KERNEL_SIZE = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    CAP  = 3'd4,
    OUT  = 3'd5,
    FIN  = 3'd6
  } state_t;

  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/kernel_row_reader_if.sv
// kernel_row_reader_if: BRAM read bus plus the triple stream to the
// convolution datapath. Signal names are from the reader's point of view.
//   o_read_en/o_addr      : one read request per cycle, data returns next cycle
//   i_data                : BRAM read data
//   o_triple/o_triple_valid/i_triple_ready : segment stream
//   o_strip_first/o_strip_last : qualifiers, meaningful only with valid
// Handshake: a triple transfers on a rising clk edge where o_triple_valid and
// i_triple_ready are both 1. Once valid rises, o_triple and the qualifiers
// stay stable and valid stays high until that transfer; ready may be driven
// freely and is ignored while valid is low.
interface kernel_row_reader_if #(
  parameter int RAM_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                   o_read_en;
  logic [ADDR_WIDTH-1:0]  o_addr;
  logic [RAM_WIDTH-1:0]   i_data;
  logic [3*RAM_WIDTH-1:0] o_triple;
  logic                   o_triple_valid;
  logic                   i_triple_ready;
  logic                   o_strip_first;
  logic                   o_strip_last;

  modport master (
    output o_read_en, o_addr, o_triple, o_triple_valid, o_strip_first, o_strip_last,
    input  i_data, i_triple_ready
  );

  modport slave (
    input  o_read_en, o_addr, o_triple, o_triple_valid, o_strip_first, o_strip_last,
    output i_data, i_triple_ready
  );
endinterface

// File: rtl/kernel_addr_counter.sv
// kernel_addr_counter: tracks the current segment position in kernel order.
//   clk, reset          : clock, async active-high reset
//   i_advance           : step to the next segment (down the strip, then next strip)
//   i_clear             : return to the frame origin
//   o_row_base          : address of the left pixel of the current segment
//   o_is_strip_first    : current segment is row 0
//   o_is_strip_last     : current segment is the bottom row
//   o_is_frame_last     : current segment is the final one of the frame
module kernel_addr_counter
  import kernel_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 10,
  parameter int IMAGE_HEIGHT = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_advance,
  input  logic                  i_clear,
  output logic [ADDR_WIDTH-1:0] o_row_base,
  output logic                  o_is_strip_first,
  output logic                  o_is_strip_last,
  output logic                  o_is_frame_last
);
  localparam int COL_W = clogb2(IMAGE_WIDTH);
  localparam int ROW_W = clogb2(IMAGE_HEIGHT);

  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;

  logic row_at_bottom;
  logic col_at_end;

  assign row_at_bottom = (row_q == ROW_W'(IMAGE_HEIGHT - 1));
  assign col_at_end    = (col_q == COL_W'(IMAGE_WIDTH - KERNEL_SIZE));

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    base_d = base_q;
    if (i_clear) begin
      col_d  = '0;
      row_d  = '0;
      base_d = '0;
    end else if (i_advance) begin
      if (!row_at_bottom) begin
        row_d  = row_q + ROW_W'(1);
        base_d = base_q + ADDR_WIDTH'(IMAGE_WIDTH);
      end else begin
        // Top of the next strip: row 0, one column to the right.
        row_d  = '0;
        col_d  = col_q + COL_W'(1);
        base_d = ADDR_WIDTH'(col_q) + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      base_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      base_q <= base_d;
    end
  end

  assign o_row_base       = base_q;
  assign o_is_strip_first = (row_q == '0);
  assign o_is_strip_last  = row_at_bottom;
  assign o_is_frame_last  = row_at_bottom && col_at_end;

endmodule

// File: rtl/kernel_row_reader.sv
// kernel_row_reader: walks a loaded frame in kernel order, reading three
// pixels per segment from BRAM and presenting them as one packed triple.
//   clk, reset     : clock, async active-high reset
//   i_start        : begin a walk (only looked at in IDLE, needs i_frame_ready)
//   i_frame_ready  : BRAM holds a complete frame
//   bus (master)   : BRAM read port and triple stream, see kernel_row_reader_if
//   o_busy         : walk in progress (any state but IDLE)
//   o_done         : one-cycle pulse after the final segment is accepted
//   o_state        : current FSM state, for observation
module kernel_row_reader
  import kernel_pkg::*;
#(
  parameter int RAM_WIDTH    = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 10,
  parameter int IMAGE_HEIGHT = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_start,
  input  logic                       i_frame_ready,
  kernel_row_reader_if.master        bus,
  output logic                       o_busy,
  output logic                       o_done,
  output state_t                     o_state
);
  state_t                state_q, state_d;
  logic [RAM_WIDTH-1:0]  p0_q, p1_q, p2_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  read_en;
  logic                  advance;
  logic                  clear;

  logic [ADDR_WIDTH-1:0] row_base;
  logic                  is_strip_first;
  logic                  is_strip_last;
  logic                  is_frame_last;

  kernel_addr_counter #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .IMAGE_WIDTH (IMAGE_WIDTH),
    .IMAGE_HEIGHT(IMAGE_HEIGHT)
  ) u_counter (
    .clk             (clk),
    .reset           (reset),
    .i_advance       (advance),
    .i_clear         (clear),
    .o_row_base      (row_base),
    .o_is_strip_first(is_strip_first),
    .o_is_strip_last (is_strip_last),
    .o_is_frame_last (is_frame_last)
  );

  // Address defaults to its previous value so it holds through CAP, OUT,
  // FIN and IDLE; only the three read states drive a new one.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    read_en = 1'b0;
    advance = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: if (i_start && i_frame_ready) state_d = RD0;
      RD0: begin
        read_en = 1'b1;
        addr_d  = row_base;
        state_d = RD1;
      end
      RD1: begin
        read_en = 1'b1;
        addr_d  = row_base + ADDR_WIDTH'(1);
        state_d = RD2;
      end
      RD2: begin
        read_en = 1'b1;
        addr_d  = row_base + ADDR_WIDTH'(2);
        state_d = CAP;
      end
      CAP: state_d = OUT;
      OUT: begin
        if (bus.i_triple_ready) begin
          advance = 1'b1;
          state_d = is_frame_last ? FIN : RD0;
        end
      end
      FIN: begin
        clear   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Read data lags the request by one cycle: the pixel requested in RD0
  // arrives during RD1, RD1's during RD2, RD2's during CAP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
    end else begin
      if (state_q == RD1) p0_q <= bus.i_data;
      if (state_q == RD2) p1_q <= bus.i_data;
      if (state_q == CAP) p2_q <= bus.i_data;
    end
  end

  assign bus.o_read_en      = read_en;
  assign bus.o_addr         = addr_d;
  assign bus.o_triple       = {p2_q, p1_q, p0_q};
  assign bus.o_triple_valid = (state_q == OUT);
  assign bus.o_strip_first  = (state_q == OUT) && is_strip_first;
  assign bus.o_strip_last   = (state_q == OUT) && is_strip_last;
  assign o_busy             = (state_q != IDLE);
  assign o_done             = (state_q == FIN);
  assign o_state            = state_q;

endmodule
